// File: rtl/chord_pkg.sv
// Shared types, pitch-class constants and small helpers for the chord arpeggiator.
package chord_pkg;

  localparam logic [3:0] PC_C  = 4'd0;
  localparam logic [3:0] PC_CS = 4'd1;
  localparam logic [3:0] PC_D  = 4'd2;
  localparam logic [3:0] PC_DS = 4'd3;
  localparam logic [3:0] PC_E  = 4'd4;
  localparam logic [3:0] PC_F  = 4'd5;
  localparam logic [3:0] PC_FS = 4'd6;
  localparam logic [3:0] PC_G  = 4'd7;
  localparam logic [3:0] PC_GS = 4'd8;
  localparam logic [3:0] PC_A  = 4'd9;
  localparam logic [3:0] PC_AS = 4'd10;
  localparam logic [3:0] PC_B  = 4'd11;

  localparam logic [15:0] REST_WORD = 16'h0000;

  typedef enum logic [1:0] {
    UP       = 2'd0,
    DOWN     = 2'd1,
    PINGPONG = 2'd2
  } arp_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    REST = 2'd2
  } arp_state_t;

  // Note idx 0 is the root in the top nibble.
  function automatic logic [3:0] pick_note(input logic [15:0] word, input logic [1:0] idx);
    logic [3:0] n;
    case (idx)
      2'd0:    n = word[15:12];
      2'd1:    n = word[11:8];
      2'd2:    n = word[7:4];
      default: n = word[3:0];
    endcase
    return n;
  endfunction

  // The unused encoding 3 plays as up.
  function automatic arp_mode_t decode_mode(input logic [1:0] m);
    arp_mode_t r;
    case (m)
      2'd1:    r = DOWN;
      2'd2:    r = PINGPONG;
      default: r = UP;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/chord_arpeggiator_step_timer.sv
// Free-running step counter; step is high during the last tick of each step.
module step_timer #(
  parameter int TICKS_PER_STEP = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic step
);

  localparam int CW = $clog2(TICKS_PER_STEP);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_STEP - 1);

  logic [CW-1:0] cnt;

  assign step = run && !clear && (cnt == LAST);

  // Count while running, hold when paused, wrap at the step boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/chord_arpeggiator.sv
// Plays a buffered four-note chord one note per step in up/down/ping-pong order.
module chord_arpeggiator
  import chord_pkg::*;
#(
  parameter int TICKS_PER_STEP = 12_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        chord_valid,
  output logic        chord_ready,
  input  logic [15:0] notes_for_chord,
  input  logic [1:0]  mode,
  input  logic        enable,
  input  logic        stop,
  output logic [3:0]  note_out,
  output logic        note_valid,
  output logic        note_strobe,
  output logic [1:0]  step_idx
);

  arp_state_t  state, state_n;
  arp_mode_t   act_mode, act_mode_n;
  logic        pending_full, pending_full_n;
  logic [15:0] pending_word, active_word, active_word_n;
  logic        dir_up, dir_up_n;
  logic [1:0]  idx_r, idx_n;
  logic [3:0]  note_r, note_n;
  logic        strobe_r, strobe_n;
  logic        load;
  logic        step;
  logic        accept;

  // stop wins over a simultaneous handshake.
  assign accept = chord_valid && !pending_full && !stop;

  step_timer #(
    .TICKS_PER_STEP(TICKS_PER_STEP)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (enable && (state != IDLE)),
    .clear((state == IDLE) || stop),
    .step (step)
  );

  // Next-state: stop, then IDLE load or boundary swap/advance.
  always_comb begin
    state_n        = state;
    act_mode_n     = act_mode;
    pending_full_n = pending_full;
    active_word_n  = active_word;
    dir_up_n       = dir_up;
    idx_n          = idx_r;
    note_n         = note_r;
    strobe_n       = 1'b0;
    load           = 1'b0;
    if (stop) begin
      state_n        = IDLE;
      pending_full_n = 1'b0;
      idx_n          = 2'd0;
      note_n         = 4'd0;
    end else begin
      if (accept) pending_full_n = 1'b1;
      case (state)
        IDLE: begin
          idx_n  = 2'd0;
          note_n = 4'd0;
          load   = pending_full && enable;
        end
        PLAY, REST: begin
          if (step) begin
            if (pending_full) begin
              load = 1'b1;
            end else if (state == PLAY) begin
              case (act_mode)
                DOWN: idx_n = idx_r - 2'd1;
                PINGPONG: begin
                  if (dir_up) begin
                    if (idx_r == 2'd3) begin
                      idx_n    = 2'd2;
                      dir_up_n = 1'b0;
                    end else begin
                      idx_n = idx_r + 2'd1;
                    end
                  end else begin
                    if (idx_r == 2'd0) begin
                      idx_n    = 2'd1;
                      dir_up_n = 1'b1;
                    end else begin
                      idx_n = idx_r - 2'd1;
                    end
                  end
                end
                default: idx_n = idx_r + 2'd1;
              endcase
              note_n   = pick_note(active_word, idx_n);
              strobe_n = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
      if (load) begin
        pending_full_n = 1'b0;
        active_word_n  = pending_word;
        act_mode_n     = decode_mode(mode);
        dir_up_n       = 1'b1;
        if (pending_word == REST_WORD) begin
          state_n = REST;
          idx_n   = 2'd0;
          note_n  = 4'd0;
        end else begin
          state_n  = PLAY;
          idx_n    = (decode_mode(mode) == DOWN) ? 2'd3 : 2'd0;
          note_n   = pick_note(pending_word, idx_n);
          strobe_n = 1'b1;
        end
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      act_mode     <= UP;
      pending_full <= 1'b0;
      dir_up       <= 1'b1;
      idx_r        <= 2'd0;
      note_r       <= 4'd0;
      strobe_r     <= 1'b0;
    end else begin
      state        <= state_n;
      act_mode     <= act_mode_n;
      pending_full <= pending_full_n;
      dir_up       <= dir_up_n;
      idx_r        <= idx_n;
      note_r       <= note_n;
      strobe_r     <= strobe_n;
    end
  end

  // Chord words are plain data; they are only observed through the control path.
  always_ff @(posedge clk) begin
    if (accept) pending_word <= notes_for_chord;
    active_word <= active_word_n;
  end

  assign chord_ready = !pending_full;
  assign note_valid  = (state == PLAY) && enable;
  assign note_strobe = strobe_r && note_valid;
  assign note_out    = note_r;
  assign step_idx    = idx_r;

endmodule

// File: tb/tb_chord_arpeggiator.sv
// Scoreboard bench for chord_arpeggiator with TICKS_PER_STEP = 4.
`timescale 1ns/1ps
module tb_chord_arpeggiator;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        chord_valid = 1'b0;
  logic        chord_ready;
  logic [15:0] notes_for_chord = 16'h0;
  logic [1:0]  mode = 2'd0;
  logic        enable = 1'b1;
  logic        stop = 1'b0;
  logic [3:0]  note_out;
  logic        note_valid;
  logic        note_strobe;
  logic [1:0]  step_idx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Expected output over a window of cycles [lo, hi].
  typedef struct {
    int         lo;
    int         hi;
    bit         vld;
    bit         strb;
    logic [3:0] note;
    logic [1:0] idx;
    bit         chkidx;
  } iv_t;
  iv_t sb[$];

  typedef struct {
    logic [15:0] w;
    logic [1:0]  m;
    int          n;
  } ch_t;
  ch_t chain[$];

  chord_arpeggiator #(.TICKS_PER_STEP(T)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .chord_valid    (chord_valid),
    .chord_ready    (chord_ready),
    .notes_for_chord(notes_for_chord),
    .mode           (mode),
    .enable         (enable),
    .stop           (stop),
    .note_out       (note_out),
    .note_valid     (note_valid),
    .note_strobe    (note_strobe),
    .step_idx       (step_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Pattern position of the k-th note after a load.
  function automatic int pat_idx(input logic [1:0] m, input int k);
    int pp[6];
    pp = '{0, 1, 2, 3, 2, 1};
    if (m == 2'd1) return 3 - (k % 4);
    if (m == 2'd2) return pp[k % 6];
    return k % 4;
  endfunction

  function automatic logic [3:0] nib(input logic [15:0] w, input int i);
    return 4'((w >> (12 - 4 * i)) & 16'hF);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  // Returns just after edge c (inputs driven here are sampled at edge c+1).
  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_iv(input int lo, input int hi, input bit vld, input bit strb,
                         input logic [3:0] note, input logic [1:0] idx, input bit chkidx);
    iv_t e;
    e.lo = lo; e.hi = hi; e.vld = vld; e.strb = strb;
    e.note = note; e.idx = idx; e.chkidx = chkidx;
    sb.push_back(e);
  endtask

  task automatic push_chord(input logic [15:0] w, input logic [1:0] m, input int n, input int L);
    for (int k = 0; k < n; k++) begin
      if (w == 16'h0)
        push_iv(L + k * T, L + (k + 1) * T - 1, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0);
      else
        push_iv(L + k * T, L + (k + 1) * T - 1, 1'b1, 1'b1,
                nib(w, pat_idx(m, k)), 2'(pat_idx(m, k)), 1'b1);
    end
  endtask

  // Handshake accepted at edge E.
  task automatic xfer(input int E, input logic [15:0] w, input logic [1:0] m);
    wait_until(E - 1);
    notes_for_chord = w;
    mode = m;
    chord_valid = 1'b1;
    chk("ready_pre_xfer", chord_ready, 1);
    wait_until(E);
    chord_valid = 1'b0;
  endtask

  // Plays each chord of 'chain' for its n notes, queueing the next one during its last note.
  task automatic run_chain();
    int E, L, Ln, En;
    E = cyc + 1;
    L = E + 1;
    xfer(E, chain[0].w, chain[0].m);
    push_chord(chain[0].w, chain[0].m, chain[0].n, L);
    for (int i = 0; i < chain.size(); i++) begin
      Ln = L + chain[i].n * T;
      if (i + 1 < chain.size()) begin
        En = L + (chain[i].n - 1) * T + 1;
        xfer(En, chain[i + 1].w, chain[i + 1].m);
        push_chord(chain[i + 1].w, chain[i + 1].m, chain[i + 1].n, Ln);
        notes_for_chord = 16'h3333;
        chord_valid = 1'b1;
        for (int c = En; c < Ln; c++) begin
          wait_until(c);
          chk("ready_while_pending", chord_ready, 0);
        end
        wait_until(Ln);
        chord_valid = 1'b0;
        chk("ready_after_swap", chord_ready, 1);
      end else begin
        wait_until(Ln - 1);
        stop = 1'b1;
        wait_until(Ln);
        stop = 1'b0;
        chk("stop_note_valid", note_valid, 0);
        chk("stop_ready", chord_ready, 1);
      end
      L = Ln;
    end
  endtask

  logic       m_v, m_s, m_ci;
  logic [3:0] m_n;
  logic [1:0] m_i;

  // Monitor: compares every cycle against the window the scoreboard expects.
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].hi < cyc) void'(sb.pop_front());
      if (sb.size() == 0 || sb[0].lo > cyc) begin
        m_v = 1'b0; m_s = 1'b0; m_n = 4'h0; m_i = 2'd0; m_ci = 1'b1;
      end else begin
        m_v = sb[0].vld;
        m_s = sb[0].strb && (sb[0].lo == cyc);
        m_n = sb[0].note;
        m_i = sb[0].idx;
        m_ci = sb[0].chkidx;
      end
      checks++;
      if (note_valid !== m_v || note_strobe !== m_s || note_out !== m_n ||
          (m_ci && step_idx !== m_i)) begin
        failures++;
        $display("FAIL monitor cyc=%0d got valid=%b strobe=%b note=%0d idx=%0d expected valid=%b strobe=%b note=%0d idx=%0d",
                 cyc, note_valid, note_strobe, note_out, step_idx, m_v, m_s, m_n, m_i);
      end
    end
  end

  initial begin
    int E, L;
    ch_t c;
    int len;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_note_out", note_out, 0);
    chk("rst_note_valid", note_valid, 0);
    chk("rst_note_strobe", note_strobe, 0);
    chk("rst_step_idx", step_idx, 0);
    chk("rst_ready", chord_ready, 1);
    rst_n = 1'b1;
    wait_until(cyc + 2);

    // Up
    chain.delete();
    c.w = 16'h047B; c.m = 2'd0; c.n = 5; chain.push_back(c);
    run_chain();
    wait_until(cyc + 2);

    // Ping-pong then down
    chain.delete();
    c.w = 16'h047B; c.m = 2'd2; c.n = 8; chain.push_back(c);
    c.w = 16'h047B; c.m = 2'd1; c.n = 5; chain.push_back(c);
    run_chain();
    wait_until(cyc + 2);

    // Mid-chord change, rest, mode 3
    chain.delete();
    c.w = 16'h047B; c.m = 2'd0; c.n = 2; chain.push_back(c);
    c.w = 16'h259C; c.m = 2'd0; c.n = 3; chain.push_back(c);
    c.w = 16'h0000; c.m = 2'd0; c.n = 2; chain.push_back(c);
    c.w = 16'h047B; c.m = 2'd3; c.n = 2; chain.push_back(c);
    run_chain();
    wait_until(cyc + 2);

    // Enable dropped for 10 cycles during the first note
    E = cyc + 1; L = E + 1;
    xfer(E, 16'h547B, 2'd0);
    push_iv(L, L, 1'b1, 1'b1, 4'd5, 2'd0, 1'b1);
    push_iv(L + 1, L + 10, 1'b0, 1'b0, 4'd5, 2'd0, 1'b1);
    push_iv(L + 11, L + 13, 1'b1, 1'b0, 4'd5, 2'd0, 1'b1);
    push_iv(L + 14, L + 17, 1'b1, 1'b1, 4'd4, 2'd1, 1'b1);
    wait_until(L + 1);
    enable = 1'b0;
    wait_until(L + 11);
    enable = 1'b1;
    wait_until(L + 17);
    stop = 1'b1;
    wait_until(L + 18);
    stop = 1'b0;
    wait_until(cyc + 2);

    // Stop mid-note with a chord pending
    E = cyc + 1; L = E + 1;
    xfer(E, 16'h047B, 2'd0);
    push_iv(L, L + 1, 1'b1, 1'b1, 4'd0, 2'd0, 1'b1);
    xfer(L + 1, 16'h259C, 2'd0);
    chk("pending_ready_low", chord_ready, 0);
    stop = 1'b1;
    wait_until(L + 2);
    stop = 1'b0;
    chk("stop_pend_valid", note_valid, 0);
    chk("stop_pend_ready", chord_ready, 1);
    wait_until(L + 10);

    // Asynchronous reset in the middle of a note
    E = cyc + 1; L = E + 1;
    xfer(E, 16'h047B, 2'd2);
    push_iv(L, L + T - 1, 1'b1, 1'b1, 4'd0, 2'd0, 1'b1);
    push_iv(L + T, L + T, 1'b1, 1'b1, 4'd4, 2'd1, 1'b1);
    wait_until(L + T + 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_note_valid", note_valid, 0);
    chk("arst_note_strobe", note_strobe, 0);
    chk("arst_note_out", note_out, 0);
    chk("arst_step_idx", step_idx, 0);
    chk("arst_ready", chord_ready, 1);
    sb.delete();
    wait_until(cyc + 3);
    rst_n = 1'b1;
    wait_until(cyc + 3);

    // Randomized chains
    for (int r = 0; r < 8; r++) begin
      chain.delete();
      len = $urandom_range(2, 5);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 5) == 0)
          c.w = 16'h0000;
        else
          c.w = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)),
                 4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
        c.m = 2'($urandom_range(0, 3));
        c.n = $urandom_range(1, 7);
        chain.push_back(c);
      end
      run_chain();
      wait_until(cyc + 2);
    end

    wait_until(cyc + 3);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
